kb_command_decoder: RTL
=======================

Name: kb_command_decoder

Overview:
- Sits between the PS/2 keyboard receiver and the game state machine.
- Replaces the bare pulse generator.
- Synchronises scan_ready into the board_clk domain and acknowledges each code with a read pulse.
- Decodes set-2 make, break (F0) and extended (E0) sequences into per-player turn requests plus start/escape requests, held pending until the game tick consumes them.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the scan_ready synchroniser (min 2).
- READ_PULSE_CYCLES, 2, read pulse width in board_clk cycles. Must be at least 2 so the half-rate keyboard clock domain samples it.

Ports:
- board_clk  input  1  system clock.
- reset  input  1  asynchronous, active-high.
- scan_ready  input  1  keyboard receiver "code available" level, asynchronous to board_clk.
- scan_code  input  8  keyboard receiver code, stable while scan_ready is high.
- tick  input  1  one-cycle pulse at each game step; consumes pending requests.
- read  output  1  acknowledge pulse to the keyboard receiver.
- p1_left  output  1  pending player-1 turn-left request (key A, 1C).
- p1_right  output  1  pending player-1 turn-right request (key D, 23).
- p2_left  output  1  pending player-2 turn-left request (E0 6B).
- p2_right  output  1  pending player-2 turn-right request (E0 74).
- start_req  output  1  pending start/ack request (space, 29).
- escape_req  output  1  pending escape request (76).
- last_code  output  8  last non-prefix code byte accepted, for SSD display.

Behaviour:
- Reset (async) values:
  - All outputs 0; last_code 8'h00.
  - Decoder state IDLE, all key-held flags cleared, synchroniser cleared.
- Synchroniser: scan_ready passes through SYNC_STAGES flops followed by a rising-edge detect.
- Edge cycle (cycle E):
  - scan_code is sampled and decoded.
  - read is asserted from E+1 for READ_PULSE_CYCLES cycles.
  - A new edge during an active read pulse is impossible by protocol; if it occurs, it is decoded and the pulse restarts.
- Latency: scan_ready rise to request output visible is SYNC_STAGES+1 board_clk cycles.
- Decoder FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. On each sampled byte:
  - IDLE: E0 -> GOT_E0; F0 -> GOT_F0; any other byte is a make (non-extended) -> IDLE.
  - GOT_E0: F0 -> GOT_E0F0; E0 -> GOT_E0; any other byte is an extended make -> IDLE.
  - GOT_F0: F0 -> GOT_F0; any other byte is a break (non-extended) -> IDLE.
  - GOT_E0F0: any byte except E0/F0 is an extended break -> IDLE; E0/F0 -> stay.
- Mapped keys: A, D, E0-6B, E0-74, space, esc. Each has a held flag.
  - Make with held=0: set held, set the request, update last_code.
  - Make with held=1 (typematic repeat): ignored; last_code unchanged.
  - Break: clear held; requests are unchanged.
  - Extended/non-extended are distinct: 6B without E0 (keypad 4) and E0 1C are unmapped.
  - Unmapped makes update last_code only.
- Opposite turns, latest wins:
  - Setting p1_left clears p1_right, and vice versa.
  - Same rule for p2_left/p2_right.
- Tick handling:
  - Tick clears all six requests on that cycle.
  - If a make is decoded in the same cycle as tick, its request is set (set beats clear). The opposite-turn clear still applies.
- Reset mid-sequence, e.g. after E0: FSM returns to IDLE and the following byte is decoded as non-extended.
- All logic is synchronous to board_clk except reset.

Decomposition:
- Shared package kb_pkg:
  - Scan-code constants: SC_E0, SC_F0, SC_A, SC_D, SC_LEFT, SC_RIGHT, SC_SPACE, SC_ESC.
  - 2-bit decoder state encoding.
  - Key index enumeration (6 keys) for the held vector.
- One sub-module: scan_ready_sync, which contains the SYNC_STAGES synchroniser, the rising-edge detect, and the read pulse stretcher.

Test Plan:
- Reset, then a single code 1C (A) -> at SYNC_STAGES+1=3 cycles after scan_ready rise: p1_left=1, last_code=1C; read high for exactly 2 cycles starting 1 cycle after the edge.
- Sequence E0,74 then tick -> p2_right=1 after the 74 byte, p1 outputs 0; the cycle after tick, p2_right=0.
- Repeat makes 23,23,23 then F0,23, then 23 -> one p1_right set only; clearing by tick between repeats does not re-set it; the make after the break sets p1_right again.
- Sequence 1C then 23 with no tick -> p1_left=0, p1_right=1.
- Make 29 decoded in the same cycle as tick, with escape_req already pending -> escape_req=0, start_req=1.
- Bytes E0, reset pulse, 6B -> no p2_left; last_code=6B; FSM in IDLE. Separately, byte 6B alone (no E0) -> no request.

Source files
------------

// File: rtl/kb_pkg.sv
// Shared definitions for the keyboard command decoder.
//   - Set-2 scan-code constants for the prefix bytes and the mapped keys.
//   - Decoder state encoding (prefix tracking).
//   - Key index enumeration that addresses the held and request vectors.
//   - map_key(): looks up an (extended, code) pair and returns the key index.
package kb_pkg;

   localparam logic [7:0] SC_E0    = 8'hE0;
   localparam logic [7:0] SC_F0    = 8'hF0;
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_D     = 8'h23;
   localparam logic [7:0] SC_LEFT  = 8'h6B;  // only with the E0 prefix
   localparam logic [7:0] SC_RIGHT = 8'h74;  // only with the E0 prefix
   localparam logic [7:0] SC_SPACE = 8'h29;
   localparam logic [7:0] SC_ESC   = 8'h76;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GOT_E0,
      ST_GOT_F0,
      ST_GOT_E0F0
   } dec_state_e;

   localparam int NUM_KEYS = 6;

   typedef enum logic [2:0] {
      KEY_P1_LEFT  = 3'd0,
      KEY_P1_RIGHT = 3'd1,
      KEY_P2_LEFT  = 3'd2,
      KEY_P2_RIGHT = 3'd3,
      KEY_START    = 3'd4,
      KEY_ESC      = 3'd5
   } key_e;

   typedef struct packed {
      logic hit;
      key_e key;
   } key_map_t;

   // Extended and plain codes are distinct keys: plain 6B (keypad 4) and
   // E0 1C fall through to "no hit".
   function automatic key_map_t map_key(input logic extended, input logic [7:0] code);
      key_map_t m;
      m.hit = 1'b1;
      m.key = KEY_P1_LEFT;
      case ({extended, code})
         {1'b0, SC_A}:     m.key = KEY_P1_LEFT;
         {1'b0, SC_D}:     m.key = KEY_P1_RIGHT;
         {1'b1, SC_LEFT}:  m.key = KEY_P2_LEFT;
         {1'b1, SC_RIGHT}: m.key = KEY_P2_RIGHT;
         {1'b0, SC_SPACE}: m.key = KEY_START;
         {1'b0, SC_ESC}:   m.key = KEY_ESC;
         default:          m.hit = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/scan_ready_sync.sv
// Brings the keyboard receiver's scan_ready level into the board_clk domain
// and acknowledges each code.
//   board_clk   : system clock
//   reset       : asynchronous, active-high
//   scan_ready  : asynchronous "code available" level
//   byte_strobe : one-cycle pulse on the synchronised rising edge (cycle E)
//   read        : registered acknowledge, high for READ_PULSE_CYCLES cycles
//                 starting the cycle after byte_strobe
module scan_ready_sync #(
   parameter int SYNC_STAGES       = 2,
   parameter int READ_PULSE_CYCLES = 2
) (
   input  logic board_clk,
   input  logic reset,
   input  logic scan_ready,
   output logic byte_strobe,
   output logic read
);

   localparam int CW = $clog2(READ_PULSE_CYCLES + 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   ready_d_q;
   logic [CW-1:0]          pulse_cnt_q;

   assign byte_strobe = sync_q[SYNC_STAGES-1] & ~ready_d_q;

   // NOTE: every flop here uses non-blocking assignment so all stages sample
   // the pre-edge values; blocking would collapse the chain into one stage.
   always_ff @(posedge board_clk or posedge reset) begin
      if (reset) begin
         sync_q      <= '0;
         ready_d_q   <= 1'b0;
         pulse_cnt_q <= '0;
         read        <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], scan_ready};
         ready_d_q <= sync_q[SYNC_STAGES-1];
         // A strobe always restarts the pulse, even mid-pulse.
         if (byte_strobe) begin
            pulse_cnt_q <= CW'(READ_PULSE_CYCLES - 1);
            read        <= 1'b1;
         end else if (pulse_cnt_q != '0) begin
            pulse_cnt_q <= pulse_cnt_q - CW'(1);
            read        <= 1'b1;
         end else begin
            read        <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/kb_command_decoder.sv
// PS/2 set-2 command decoder between the keyboard receiver and the game FSM.
//   board_clk  : system clock
//   reset      : asynchronous, active-high
//   scan_ready : receiver "code available" level (asynchronous)
//   scan_code  : receiver code byte, stable while scan_ready is high
//   tick       : game-step pulse; consumes all pending requests
//   read       : acknowledge pulse back to the receiver
//   p1_left/p1_right/p2_left/p2_right/start_req/escape_req : pending requests
//   last_code  : last non-prefix code accepted (for display)
module kb_command_decoder
   import kb_pkg::*;
#(
   parameter int SYNC_STAGES       = 2,
   parameter int READ_PULSE_CYCLES = 2
) (
   input  logic       board_clk,
   input  logic       reset,
   input  logic       scan_ready,
   input  logic [7:0] scan_code,
   input  logic       tick,
   output logic       read,
   output logic       p1_left,
   output logic       p1_right,
   output logic       p2_left,
   output logic       p2_right,
   output logic       start_req,
   output logic       escape_req,
   output logic [7:0] last_code
);

   logic                byte_strobe;
   dec_state_e          state_q, state_next;
   logic [NUM_KEYS-1:0] held_q, held_next;
   logic [NUM_KEYS-1:0] req_q, req_next;
   logic [7:0]          last_q, last_next;
   logic                is_make, is_break, is_ext;
   key_map_t            km;

   scan_ready_sync #(
      .SYNC_STAGES       (SYNC_STAGES),
      .READ_PULSE_CYCLES (READ_PULSE_CYCLES)
   ) u_sync (
      .board_clk   (board_clk),
      .reset       (reset),
      .scan_ready  (scan_ready),
      .byte_strobe (byte_strobe),
      .read        (read)
   );

   // NOTE: every signal driven here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      state_next = state_q;
      is_make    = 1'b0;
      is_break   = 1'b0;
      is_ext     = 1'b0;
      if (byte_strobe) begin
         case (state_q)
            ST_IDLE: begin
               if (scan_code == SC_E0)      state_next = ST_GOT_E0;
               else if (scan_code == SC_F0) state_next = ST_GOT_F0;
               else                         is_make    = 1'b1;
            end
            ST_GOT_E0: begin
               if (scan_code == SC_F0)      state_next = ST_GOT_E0F0;
               else if (scan_code != SC_E0) begin
                  is_make    = 1'b1;
                  is_ext     = 1'b1;
                  state_next = ST_IDLE;
               end
            end
            ST_GOT_F0: begin
               if (scan_code != SC_F0) begin
                  is_break   = 1'b1;
                  state_next = ST_IDLE;
               end
            end
            default: begin  // ST_GOT_E0F0
               if (scan_code != SC_E0 && scan_code != SC_F0) begin
                  is_break   = 1'b1;
                  is_ext     = 1'b1;
                  state_next = ST_IDLE;
               end
            end
         endcase
      end

      km = map_key(is_ext, scan_code);

      // Tick clears first; a make in the same cycle then sets (set beats clear).
      req_next  = tick ? '0 : req_q;
      held_next = held_q;
      last_next = last_q;

      if (is_make) begin
         if (!km.hit) begin
            last_next = scan_code;
         end else if (!held_q[km.key]) begin
            held_next[km.key] = 1'b1;
            req_next[km.key]  = 1'b1;
            last_next         = scan_code;
            // Opposite turns: the latest request wins.
            case (km.key)
               KEY_P1_LEFT:  req_next[KEY_P1_RIGHT] = 1'b0;
               KEY_P1_RIGHT: req_next[KEY_P1_LEFT]  = 1'b0;
               KEY_P2_LEFT:  req_next[KEY_P2_RIGHT] = 1'b0;
               KEY_P2_RIGHT: req_next[KEY_P2_LEFT]  = 1'b0;
               default: ;
            endcase
         end
      end else if (is_break && km.hit) begin
         held_next[km.key] = 1'b0;
      end
   end

   always_ff @(posedge board_clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         held_q  <= '0;
         req_q   <= '0;
         last_q  <= 8'h00;
      end else begin
         state_q <= state_next;
         held_q  <= held_next;
         req_q   <= req_next;
         last_q  <= last_next;
      end
   end

   assign p1_left    = req_q[KEY_P1_LEFT];
   assign p1_right   = req_q[KEY_P1_RIGHT];
   assign p2_left    = req_q[KEY_P2_LEFT];
   assign p2_right   = req_q[KEY_P2_RIGHT];
   assign start_req  = req_q[KEY_START];
   assign escape_req = req_q[KEY_ESC];
   assign last_code  = last_q;

endmodule
